fft3d_sequencer: RTL and testbench
==================================

FFT3D_SEQUENCER -- requirements
Module: fft3d_sequencer

Interface
REQ-001 SHALL have parameter DIMENSION, default 16, meaning grid points per axis.
REQ-002 SHALL have parameter DIMENSION_LOG, default 4, meaning log2(DIMENSION).
REQ-003 SHALL have parameter FFT_LATENCY, default 8, meaning FFT core issue-to-result cycles (>=1).
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  meaning synchronous active-high reset.
REQ-006 SHALL have port start  input  1  meaning begin a transform sequence; sampled in IDLE only.
REQ-007 SHALL have port skip_charge  input  1  meaning bypass CHARGE phase; latched with start.
REQ-008 SHALL have port inverse  input  1  meaning inverse transform; latched with start.
REQ-009 SHALL have port abort  input  1  meaning terminate sequence.
REQ-010 SHALL have port cm_done  input  1  meaning charge mapping finished.
REQ-011 SHALL have port fft_ready  input  1  meaning FFT cores accept an issue this cycle.
REQ-012 SHALL have port FFT_dim  output  3  meaning phase code: 0 CHARGE, 1 X, 2 Y, 4 Z, 3 idle/done.
REQ-013 SHALL have port FFT_iteration  output  11  meaning current read line index.
REQ-014 SHALL have port fft_valid  output  1  meaning a line is issued this cycle.
REQ-015 SHALL have port fft_inverse  output  1  meaning latched inverse flag.
REQ-016 SHALL have port FFTwren  output  DIMENSION  meaning write-back enable, all bits equal.
REQ-017 SHALL have port wr_iteration  output  11  meaning line index of current write-back.
REQ-018 SHALL have port busy  output  1  meaning state is not IDLE.
REQ-019 SHALL have port done  output  1  meaning one-cycle completion pulse.

Function
REQ-020 SHALL implement states IDLE, CHARGE, PASS_X, PASS_Y, PASS_Z, DONE.
REQ-021 SHALL move IDLE->CHARGE on start=1, or IDLE->PASS_X on start=1 with skip_charge=1.
REQ-022 SHALL move CHARGE->PASS_X on the cycle after cm_done=1; cm_done in other states is ignored.
REQ-023 SHALL define N=DIMENSION*DIMENSION; a pass issues iterations 0..N-1 in order.
REQ-024 SHALL issue one line per cycle while fft_ready=1; when fft_ready=0, fft_valid=0 and FFT_iteration holds.
REQ-025 SHALL hold FFT_iteration at N-1 with fft_valid=0 once all N lines are issued.
REQ-026 SHALL delay fft_valid and FFT_iteration exactly FFT_LATENCY cycles to form FFTwren and wr_iteration; stall bubbles propagate as FFTwren=0.
REQ-027 SHALL leave a pass on the cycle after its N-th write-back: PASS_X->PASS_Y->PASS_Z->DONE.
REQ-028 SHALL make a stall-free pass last exactly N+FFT_LATENCY cycles, with first issue in the pass's first cycle.
REQ-029 SHALL assert done for the single DONE cycle, then return to IDLE.
REQ-030 SHALL ignore start while busy=1.
REQ-031 SHALL, on abort in any non-IDLE state, enter IDLE next cycle, clear the delay line and counters, and not pulse done.
REQ-032 SHALL give abort priority over start, cm_done and pass completion in the same cycle.
REQ-033 SHALL drive FFT_dim=3 and FFT_iteration=0 in IDLE and DONE.

Reset
REQ-034 SHALL, on rst=1, enter IDLE and clear the delay line; next cycle FFT_dim=3, FFT_iteration=0, fft_valid=0, FFTwren=0, wr_iteration=0, busy=0, done=0, fft_inverse=0.
REQ-035 SHALL honor rst mid-pass identically, discarding in-flight write-backs.

Structure
REQ-036 SHALL place the state enum and FFT_dim codes (DIM_CHARGE, DIM_X, DIM_Y, DIM_Z, DIM_IDLE) in shared package fft_seq_pkg.
REQ-037 SHALL implement the valid/iteration delay as sub-module fft_wb_delay, parameterized by FFT_LATENCY and width.
REQ-038 SHALL reject by elaboration check N>2048 or DIMENSION!=2**DIMENSION_LOG.

Verification (N=256, FFT_LATENCY=8)
REQ-039 SHALL cover start at cycle 0 with skip_charge=1 and fft_ready=1 -> PASS_X cycles 1-264, PASS_Y 265-528, PASS_Z 529-792, done pulse at 793 only.
REQ-040 SHALL cover skip_charge=0 with cm_done at cycle 20 -> FFT_dim=0 cycles 1-20, FFT_dim=1 from 21.
REQ-041 SHALL cover fft_ready=0 for 5 cycles at iteration 100 in PASS_Y -> iteration holds 100, FFTwren low for 5 cycles 8 later, pass lengthens by 5.
REQ-042 SHALL cover abort at iteration 50 of PASS_Z -> IDLE next cycle, FFTwren=0 thereafter, no done.
REQ-043 SHALL cover start asserted during PASS_X and rst at iteration 30 -> start ignored; reset values of REQ-034 next cycle.
REQ-044 SHALL cover inverse=1 at start, toggled during passes -> fft_inverse=1 throughout the sequence.

Source files
------------

// File: rtl/fft_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fft_seq_pkg
// Purpose : Shared types and constants for the 3-D FFT pass sequencer:
//           sequencer state encoding and the FFT_dim phase codes seen by the
//           FFT cores and the grid memory.
// Revision: 1.0  initial release
// ============================================================================
package fft_seq_pkg;

    // Explicit 3-bit encoding so the state register width is fixed.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHARGE = 3'd1,
        ST_PASS_X = 3'd2,
        ST_PASS_Y = 3'd3,
        ST_PASS_Z = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_t;

    // Phase codes on FFT_dim. X/Y/Z are one-hot so downstream address
    // generators can select the axis with a single bit.
    localparam logic [2:0] DIM_CHARGE = 3'd0;
    localparam logic [2:0] DIM_X      = 3'd1;
    localparam logic [2:0] DIM_Y      = 3'd2;
    localparam logic [2:0] DIM_Z      = 3'd4;
    localparam logic [2:0] DIM_IDLE   = 3'd3;

    // Line index width; bounds the grid to 2048 lines per pass.
    localparam int ITER_W    = 11;
    localparam int MAX_LINES = 2048;

    function automatic logic is_pass_state(input seq_state_t s);
        return (s == ST_PASS_X) || (s == ST_PASS_Y) || (s == ST_PASS_Z);
    endfunction

endpackage : fft_seq_pkg
`default_nettype wire

// File: rtl/fft_wb_delay.sv
`default_nettype none
// ============================================================================
// Module  : fft_wb_delay
// Purpose : Fixed-latency shift register that turns an FFT issue (valid +
//           line index) into the matching write-back LATENCY cycles later.
//           Bubbles travel through as valid=0.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           i_clr         - synchronous flush (same effect as rst)
//           i_valid/i_data- issue side
//           o_valid/o_data- write-back side, LATENCY cycles later
// Revision: 1.0  initial release
// ============================================================================
module fft_wb_delay #(
    parameter int LATENCY = 8,
    parameter int WIDTH   = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic [LATENCY-1:0] r_vld;
    logic [WIDTH-1:0]   r_dat [LATENCY];

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_valid;
            r_dat[0] <= i_data;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    assign o_valid = r_vld[LATENCY-1];
    assign o_data  = r_dat[LATENCY-1];

endmodule : fft_wb_delay
`default_nettype wire

// File: rtl/fft3d_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : fft3d_sequencer
// Purpose : Sequences a 3-D FFT over a DIMENSION^3 grid: optional CHARGE
//           phase (wait for charge mapping), then X, Y and Z passes of
//           DIMENSION^2 line transforms each, then a one-cycle done pulse.
//           Lines are issued one per cycle while fft_ready is high; each
//           issue returns as a write-back FFT_LATENCY cycles later.
// Ports   : clk, rst         - clock, synchronous active-high reset
//           start            - begin sequence (IDLE only)
//           skip_charge      - go straight to the X pass
//           inverse          - inverse transform flag, latched with start
//           abort            - terminate sequence, no done pulse
//           cm_done          - charge mapping finished (CHARGE only)
//           fft_ready        - FFT cores accept an issue this cycle
//           FFT_dim          - phase code (see fft_seq_pkg)
//           FFT_iteration    - current read line index
//           fft_valid        - line issued this cycle
//           fft_inverse      - latched inverse flag
//           FFTwren          - write-back enable, replicated per lane
//           wr_iteration     - line index of current write-back
//           busy, done       - status
// Revision: 1.0  initial release
// ============================================================================
module fft3d_sequencer
    import fft_seq_pkg::*;
#(
    parameter int DIMENSION     = 16,
    parameter int DIMENSION_LOG = 4,
    parameter int FFT_LATENCY   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 skip_charge,
    input  logic                 inverse,
    input  logic                 abort,
    input  logic                 cm_done,
    input  logic                 fft_ready,
    output logic [2:0]           FFT_dim,
    output logic [10:0]          FFT_iteration,
    output logic                 fft_valid,
    output logic                 fft_inverse,
    output logic [DIMENSION-1:0] FFTwren,
    output logic [10:0]          wr_iteration,
    output logic                 busy,
    output logic                 done
);

    localparam int              c_LINES     = DIMENSION * DIMENSION;
    localparam logic [ITER_W-1:0] c_LAST_LINE = ITER_W'(c_LINES - 1);

    // Elaboration-time parameter sanity.
    generate
        if ((c_LINES > MAX_LINES) || (DIMENSION != (1 << DIMENSION_LOG)) ||
            (FFT_LATENCY < 1)) begin : g_param_check
            $error("fft3d_sequencer: illegal DIMENSION/DIMENSION_LOG/FFT_LATENCY");
        end
    endgenerate

    seq_state_t         r_state;
    seq_state_t         w_next_state;
    logic [ITER_W-1:0]  r_iss_cnt;
    logic               r_iss_done;
    logic               r_inverse;
    logic               w_abort_hit;
    logic               w_wb_valid;
    logic [ITER_W-1:0]  w_wb_iter;
    logic               w_last_wb;

    // Abort only means something once a sequence is running.
    assign w_abort_hit = abort && (r_state != ST_IDLE);

    // Lines return in issue order, so the write-back carrying the last index
    // is the N-th write-back of the pass.
    assign w_last_wb = w_wb_valid && (w_wb_iter == c_LAST_LINE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = skip_charge ? ST_PASS_X : ST_CHARGE;
                end
            end
            ST_CHARGE: begin
                if (cm_done) begin
                    w_next_state = ST_PASS_X;
                end
            end
            ST_PASS_X: if (w_last_wb) w_next_state = ST_PASS_Y;
            ST_PASS_Y: if (w_last_wb) w_next_state = ST_PASS_Z;
            ST_PASS_Z: if (w_last_wb) w_next_state = ST_DONE;
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
        // Abort outranks every other transition.
        if (w_abort_hit) begin
            w_next_state = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        FFT_dim       = DIM_IDLE;
        fft_valid     = 1'b0;
        FFT_iteration = '0;
        busy          = (r_state != ST_IDLE);
        done          = 1'b0;
        case (r_state)
            ST_CHARGE: begin
                FFT_dim       = DIM_CHARGE;
                FFT_iteration = r_iss_cnt;
            end
            ST_PASS_X: FFT_dim = DIM_X;
            ST_PASS_Y: FFT_dim = DIM_Y;
            ST_PASS_Z: FFT_dim = DIM_Z;
            ST_DONE:   done    = !abort;
            default:   FFT_dim = DIM_IDLE;
        endcase
        if (is_pass_state(r_state)) begin
            fft_valid     = fft_ready && !r_iss_done;
            FFT_iteration = r_iss_cnt;
        end
    end

    // ------------------------------------------------------------------
    // Issue counter: counts 0..N-1, then parks at N-1 with r_iss_done set.
    // Cleared on every state change so each pass starts from line 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || w_abort_hit || (w_next_state != r_state)) begin
            r_iss_cnt  <= '0;
            r_iss_done <= 1'b0;
        end else if (fft_valid) begin
            if (r_iss_cnt == c_LAST_LINE) begin
                r_iss_done <= 1'b1;
            end else begin
                r_iss_cnt <= r_iss_cnt + ITER_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Inverse flag: captured only when a sequence is accepted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inverse <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_inverse <= inverse;
        end
    end

    assign fft_inverse = r_inverse;

    // ------------------------------------------------------------------
    // Write-back delay line
    // ------------------------------------------------------------------
    fft_wb_delay #(
        .LATENCY (FFT_LATENCY),
        .WIDTH   (ITER_W)
    ) u_wb_delay (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_abort_hit),
        .i_valid (fft_valid),
        .i_data  (FFT_iteration),
        .o_valid (w_wb_valid),
        .o_data  (w_wb_iter)
    );

    assign FFTwren      = {DIMENSION{w_wb_valid}};
    assign wr_iteration = w_wb_iter;

endmodule : fft3d_sequencer
`default_nettype wire

// File: tb/tb_fft3d_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fft3d_sequencer
// Purpose : Self-checking bench for fft3d_sequencer (DIMENSION=16, N=256,
//           FFT_LATENCY=8). A phase/count model with an issue history
//           predicts every output each cycle; directed sequences add
//           hand-computed cycle-exact expectations.
// Revision: 1.0  initial release
// ============================================================================
module tb_fft3d_sequencer;

    localparam int DIM  = 16;
    localparam int N    = DIM * DIM;
    localparam int L    = 8;
    localparam int HMAX = 4096;

    localparam int PH_IDLE = 0, PH_CHG = 1, PH_X = 2, PH_Y = 3, PH_Z = 4, PH_DONE = 5;

    logic           clk = 1'b0;
    logic           rst, start, skip_charge, inverse, abort, cm_done, fft_ready;
    logic [2:0]     FFT_dim;
    logic [10:0]    FFT_iteration;
    logic           fft_valid;
    logic           fft_inverse;
    logic [DIM-1:0] FFTwren;
    logic [10:0]    wr_iteration;
    logic           busy;
    logic           done;

    int n_chk = 0;
    int n_err = 0;

    fft3d_sequencer #(
        .DIMENSION     (DIM),
        .DIMENSION_LOG (4),
        .FFT_LATENCY   (L)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .skip_charge   (skip_charge),
        .inverse       (inverse),
        .abort         (abort),
        .cm_done       (cm_done),
        .fft_ready     (fft_ready),
        .FFT_dim       (FFT_dim),
        .FFT_iteration (FFT_iteration),
        .fft_valid     (fft_valid),
        .fft_inverse   (fft_inverse),
        .FFTwren       (FFTwren),
        .wr_iteration  (wr_iteration),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: phase, lines issued / written back in this pass,
    // and a per-cycle record of what was issued. A write-back is simply
    // whatever was issued L cycles earlier, unless a flush happened since.
    // ------------------------------------------------------------------
    int  m_cyc   = 0;
    int  m_ph    = PH_IDLE;
    int  m_iss   = 0;
    int  m_wb    = 0;
    int  m_clear = 0;
    bit  m_inv   = 1'b0;
    bit  m_sync  = 1'b0;
    bit  iss_v  [HMAX];
    int  iss_it [HMAX];

    bit  e_valid, e_done, e_busy, e_wren;
    int  e_iter, e_dim, e_writ, e_idx;

    always_comb begin
        e_valid = 1'b0;
        e_iter  = 0;
        e_dim   = 3;
        e_busy  = (m_ph != PH_IDLE);
        e_done  = 1'b0;
        e_wren  = 1'b0;
        e_writ  = 0;
        e_idx   = m_cyc - L;
        case (m_ph)
            PH_CHG:  e_dim = 0;
            PH_X:    e_dim = 1;
            PH_Y:    e_dim = 2;
            PH_Z:    e_dim = 4;
            PH_DONE: e_done = !abort;
            default: e_dim = 3;
        endcase
        if (m_ph == PH_X || m_ph == PH_Y || m_ph == PH_Z) begin
            e_valid = fft_ready && (m_iss < N);
            e_iter  = (m_iss < N) ? m_iss : N - 1;
        end
        if (e_idx >= 0 && e_idx >= m_clear && e_idx < HMAX) begin
            e_wren = iss_v[e_idx];
            e_writ = iss_it[e_idx];
        end
    end

    always @(posedge clk) begin
        if (m_cyc < HMAX) begin
            iss_v[m_cyc]  <= e_valid;
            iss_it[m_cyc] <= e_iter;
        end
        m_cyc  <= m_cyc + 1;
        m_sync <= 1'b1;
        if (rst) begin
            m_ph <= PH_IDLE; m_iss <= 0; m_wb <= 0; m_clear <= m_cyc + 1; m_inv <= 1'b0;
        end else if (abort && m_ph != PH_IDLE) begin
            m_ph <= PH_IDLE; m_iss <= 0; m_wb <= 0; m_clear <= m_cyc + 1;
        end else begin
            case (m_ph)
                PH_IDLE: if (start) begin
                    m_inv <= inverse;
                    m_ph  <= skip_charge ? PH_X : PH_CHG;
                end
                PH_CHG: if (cm_done) m_ph <= PH_X;
                PH_X, PH_Y, PH_Z: begin
                    if (e_wren && m_wb == N - 1) begin
                        m_ph <= m_ph + 1; m_iss <= 0; m_wb <= 0;
                    end else begin
                        m_iss <= m_iss + int'(e_valid);
                        m_wb  <= m_wb + int'(e_wren);
                    end
                end
                PH_DONE: m_ph <= PH_IDLE;
                default: m_ph <= PH_IDLE;
            endcase
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, m_cyc, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_sync) begin
            chk("FFT_dim",       int'(FFT_dim),       e_dim);
            chk("FFT_iteration", int'(FFT_iteration), e_iter);
            chk("fft_valid",     int'(fft_valid),     int'(e_valid));
            chk("fft_inverse",   int'(fft_inverse),   int'(m_inv));
            chk("FFTwren",       int'(FFTwren),       int'({DIM{e_wren}}));
            chk("wr_iteration",  int'(wr_iteration),  e_writ);
            chk("busy",          int'(busy),          int'(e_busy));
            chk("done",          int'(done),          int'(e_done));
        end
    end

    // Inputs change 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed sequences; cycle 0 is the cycle in which start is high.
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1; start = 1'b0; skip_charge = 1'b0; inverse = 1'b0;
        abort = 1'b0; cm_done = 1'b0; fft_ready = 1'b1;
        step(); step();
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset dim",  int'(FFT_dim), 3);
        chk("reset wren", int'(FFTwren), 0);
        step();
        rst = 1'b0;
        step();

        // Stall-free sequence, charge skipped.
        start = 1'b1; skip_charge = 1'b1;
        for (int c = 1; c <= 795; c++) begin
            step();
            start = 1'b0;
            #1;
            case (c)
                1:   begin chk("t1 dim@1", int'(FFT_dim), 1); chk("t1 valid@1", int'(fft_valid), 1);
                           chk("t1 iter@1", int'(FFT_iteration), 0); end
                8:   chk("t1 wren@8", int'(FFTwren), 0);
                9:   begin chk("t1 wren@9", int'(FFTwren), 16'hFFFF); chk("t1 writ@9", int'(wr_iteration), 0); end
                257: begin chk("t1 iter@257", int'(FFT_iteration), 255); chk("t1 valid@257", int'(fft_valid), 0); end
                264: begin chk("t1 dim@264", int'(FFT_dim), 1); chk("t1 writ@264", int'(wr_iteration), 255); end
                265: chk("t1 dim@265", int'(FFT_dim), 2);
                528: chk("t1 dim@528", int'(FFT_dim), 2);
                529: chk("t1 dim@529", int'(FFT_dim), 4);
                792: begin chk("t1 dim@792", int'(FFT_dim), 4); chk("t1 done@792", int'(done), 0); end
                793: begin chk("t1 done@793", int'(done), 1); chk("t1 dim@793", int'(FFT_dim), 3); end
                794: begin chk("t1 done@794", int'(done), 0); chk("t1 busy@794", int'(busy), 0); end
                default: ;
            endcase
        end

        // Charge phase with cm_done at cycle 20; stray cm_done at 25; abort at 30.
        start = 1'b1; skip_charge = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            step();
            start   = 1'b0;
            cm_done = (c == 20 || c == 25);
            abort   = (c == 30);
            #1;
            case (c)
                1:  begin chk("t2 dim@1", int'(FFT_dim), 0); chk("t2 busy@1", int'(busy), 1); end
                20: chk("t2 dim@20", int'(FFT_dim), 0);
                21: begin chk("t2 dim@21", int'(FFT_dim), 1); chk("t2 iter@21", int'(FFT_iteration), 0); end
                22: chk("t2 iter@22", int'(FFT_iteration), 1);
                31: begin chk("t2 busy@31", int'(busy), 0); chk("t2 wren@31", int'(FFTwren), 0); end
                default: ;
            endcase
        end
        cm_done = 1'b0; abort = 1'b0;

        // Inverse sequence with 5-cycle stall at iteration 100 of PASS_Y.
        start = 1'b1; skip_charge = 1'b1; inverse = 1'b1;
        for (int c = 1; c <= 800; c++) begin
            step();
            start     = 1'b0;
            inverse   = c[0];
            fft_ready = !(c >= 365 && c <= 369);
            #1;
            case (c)
                2:   chk("t3 inv@2", int'(fft_inverse), 1);
                365: begin chk("t3 iter@365", int'(FFT_iteration), 100); chk("t3 valid@365", int'(fft_valid), 0); end
                369: chk("t3 iter@369", int'(FFT_iteration), 100);
                370: begin chk("t3 iter@370", int'(FFT_iteration), 100); chk("t3 valid@370", int'(fft_valid), 1); end
                372: begin chk("t3 wren@372", int'(FFTwren), 16'hFFFF); chk("t3 writ@372", int'(wr_iteration), 99); end
                373: chk("t3 wren@373", int'(FFTwren), 0);
                377: chk("t3 wren@377", int'(FFTwren), 0);
                378: begin chk("t3 wren@378", int'(FFTwren), 16'hFFFF); chk("t3 writ@378", int'(wr_iteration), 100); end
                533: chk("t3 dim@533", int'(FFT_dim), 2);
                534: chk("t3 dim@534", int'(FFT_dim), 4);
                600: chk("t3 inv@600", int'(fft_inverse), 1);
                797: chk("t3 dim@797", int'(FFT_dim), 4);
                798: begin chk("t3 done@798", int'(done), 1); chk("t3 inv@798", int'(fft_inverse), 1); end
                799: chk("t3 busy@799", int'(busy), 0);
                default: ;
            endcase
        end
        inverse = 1'b0; fft_ready = 1'b1;

        // Abort at iteration 50 of PASS_Z.
        start = 1'b1; skip_charge = 1'b1;
        for (int c = 1; c <= 600; c++) begin
            step();
            start = 1'b0;
            abort = (c == 579);
            #1;
            case (c)
                579: begin chk("t4 dim@579", int'(FFT_dim), 4); chk("t4 iter@579", int'(FFT_iteration), 50); end
                580: begin chk("t4 busy@580", int'(busy), 0); chk("t4 dim@580", int'(FFT_dim), 3);
                           chk("t4 wren@580", int'(FFTwren), 0); chk("t4 done@580", int'(done), 0); end
                590, 600: begin chk("t4 wren late", int'(FFTwren), 0); chk("t4 done late", int'(done), 0); end
                default: ;
            endcase
        end
        abort = 1'b0;

        // start ignored while busy; reset at iteration 30 of PASS_X.
        start = 1'b1; skip_charge = 1'b1; inverse = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            step();
            start = (c >= 10 && c <= 31);
            rst   = (c == 31);
            #1;
            case (c)
                20: begin chk("t5 dim@20", int'(FFT_dim), 1); chk("t5 iter@20", int'(FFT_iteration), 19); end
                31: chk("t5 iter@31", int'(FFT_iteration), 30);
                32: begin
                    chk("t5 dim@32",  int'(FFT_dim), 3);       chk("t5 iter@32", int'(FFT_iteration), 0);
                    chk("t5 valid@32", int'(fft_valid), 0);   chk("t5 wren@32", int'(FFTwren), 0);
                    chk("t5 writ@32", int'(wr_iteration), 0); chk("t5 busy@32", int'(busy), 0);
                    chk("t5 done@32", int'(done), 0);         chk("t5 inv@32",  int'(fft_inverse), 0);
                end
                40: chk("t5 busy@40", int'(busy), 0);
                default: ;
            endcase
        end
        rst = 1'b0; start = 1'b0; inverse = 1'b0;

        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_fft3d_sequencer
`default_nettype wire
